// File: rtl/cpu_hazard_pkg.sv
// Shared hazard-control definitions: forwarding select codes, Tuse "never"
// value, mult/div operation classes, pipeline shadow records and helpers.
package cpu_hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_E    = 2'd1;
  localparam logic [1:0] FWD_M    = 2'd2;
  localparam logic [1:0] FWD_W    = 2'd3;

  localparam logic [2:0] TUSE_NEVER = 3'd7;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_HILO = 2'd3
  } md_op_e;

  // Shadow descriptor of the instruction sitting in E.
  typedef struct packed {
    logic [4:0] waddr;
    logic [2:0] tnew;
    logic [4:0] raddr0;
    logic [4:0] raddr1;
    md_op_e     md_op;
  } e_stage_t;

  // M keeps raddr1 because store data may still need a W forward.
  typedef struct packed {
    logic [4:0] waddr;
    logic [2:0] tnew;
    logic [4:0] raddr1;
  } m_stage_t;

  typedef struct packed {
    logic [4:0] waddr;
    logic [2:0] tnew;
  } w_stage_t;

  // Tnew ages by one per stage move and never goes below zero.
  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  // Reader needs the value sooner than the producer can supply it.
  function automatic logic late_hit(input logic [4:0] raddr, input logic [2:0] tuse,
                                    input logic [4:0] waddr, input logic [2:0] tnew);
    return (raddr != 5'd0) && (raddr == waddr) && (tuse < tnew);
  endfunction

  // Producer holds a finished result for this register.
  function automatic logic fwd_ok(input logic [4:0] raddr, input logic [4:0] waddr,
                                  input logic [2:0] tnew);
    return (raddr != 5'd0) && (raddr == waddr) && (tnew == 3'd0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decoder/datapath <-> hazard controller bundle.
// Handshake: there is no valid/ready pair. The D-stage descriptor qualifies
// itself (address 0 = no operand / no write, Tuse 7 = never read); the
// controller answers in the same cycle, and stall is the only backpressure:
// while stall=1 the D-stage descriptor must be held and is not consumed.
interface hazard_ctrl_if;
  logic [4:0] d_raddr0;
  logic [4:0] d_raddr1;
  logic [2:0] d_tuse0;
  logic [2:0] d_tuse1;
  logic [4:0] d_waddr;
  logic [2:0] d_tnew;
  logic [1:0] d_md_op;
  logic       stall;
  logic [1:0] fwd_d_rs;
  logic [1:0] fwd_d_rt;
  logic [1:0] fwd_e_rs;
  logic [1:0] fwd_e_rt;
  logic       fwd_m_rt;

  modport master (
    output d_raddr0, d_raddr1, d_tuse0, d_tuse1, d_waddr, d_tnew, d_md_op,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );

  modport slave (
    input  d_raddr0, d_raddr1, d_tuse0, d_tuse1, d_waddr, d_tnew, d_md_op,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );
endinterface

// File: rtl/md_busy_ctr.sv
// Mult/div unit occupancy counter: loads the operation latency when a
// mult/div leaves E, then counts down to idle.
module md_busy_ctr #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start_mult,
  input  logic start_div,
  output logic busy
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load on a new start, otherwise drain towards zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start_mult)            cnt_d = CW'(MULT_CYCLES);
    else if (start_div)        cnt_d = CW'(DIV_CYCLES);
    else if (cnt_q != '0)      cnt_d = cnt_q - CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows the E/M/W descriptors, ages Tnew,
// raises the stall and drives the operand forwarding selects.
// Optional: HAZARD_STALL_CNT_EN adds a free-running stall cycle counter.
import cpu_hazard_pkg::*;

module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  hazard_ctrl_if.slave       hz
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  e_stage_t e_q, e_d;
  m_stage_t m_q, m_d;
  w_stage_t w_q, w_d;
  logic     data_stall, md_stall, stall, md_busy;
  md_op_e   d_md;

  assign d_md = md_op_e'(hz.d_md_op);

  md_busy_ctr #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy (
    .clk       (clk),
    .reset     (reset),
    .start_mult(e_q.md_op == MD_MULT),
    .start_div (e_q.md_op == MD_DIV),
    .busy      (md_busy)
  );

  // Stall decision from current shadows and the D-stage descriptor.
  always_comb begin
    data_stall = late_hit(hz.d_raddr0, hz.d_tuse0, e_q.waddr, e_q.tnew) |
                 late_hit(hz.d_raddr1, hz.d_tuse1, e_q.waddr, e_q.tnew) |
                 late_hit(hz.d_raddr0, hz.d_tuse0, m_q.waddr, m_q.tnew) |
                 late_hit(hz.d_raddr1, hz.d_tuse1, m_q.waddr, m_q.tnew);
    md_stall   = (d_md != MD_NONE) &&
                 (md_busy || (e_q.md_op == MD_MULT) || (e_q.md_op == MD_DIV));
    stall      = data_stall | md_stall;
  end

  assign hz.stall = stall;

  // Next shadow contents: D enters E unless stalled (then a bubble), the rest shift.
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.waddr  = hz.d_waddr;
      e_d.tnew   = sat_dec(hz.d_tnew);
      e_d.raddr0 = hz.d_raddr0;
      e_d.raddr1 = hz.d_raddr1;
      e_d.md_op  = d_md;
    end
    m_d.waddr  = e_q.waddr;
    m_d.tnew   = sat_dec(e_q.tnew);
    m_d.raddr1 = e_q.raddr1;
    w_d.waddr  = m_q.waddr;
    w_d.tnew   = sat_dec(m_q.tnew);
  end

  // Shadow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Forwarding selects: nearest stage holding a finished result wins.
  always_comb begin
    hz.fwd_d_rs = FWD_NONE;
    if      (fwd_ok(hz.d_raddr0, e_q.waddr, e_q.tnew)) hz.fwd_d_rs = FWD_E;
    else if (fwd_ok(hz.d_raddr0, m_q.waddr, m_q.tnew)) hz.fwd_d_rs = FWD_M;
    else if (fwd_ok(hz.d_raddr0, w_q.waddr, w_q.tnew)) hz.fwd_d_rs = FWD_W;

    hz.fwd_d_rt = FWD_NONE;
    if      (fwd_ok(hz.d_raddr1, e_q.waddr, e_q.tnew)) hz.fwd_d_rt = FWD_E;
    else if (fwd_ok(hz.d_raddr1, m_q.waddr, m_q.tnew)) hz.fwd_d_rt = FWD_M;
    else if (fwd_ok(hz.d_raddr1, w_q.waddr, w_q.tnew)) hz.fwd_d_rt = FWD_W;

    hz.fwd_e_rs = FWD_NONE;
    if      (fwd_ok(e_q.raddr0, m_q.waddr, m_q.tnew)) hz.fwd_e_rs = FWD_M;
    else if (fwd_ok(e_q.raddr0, w_q.waddr, w_q.tnew)) hz.fwd_e_rs = FWD_W;

    hz.fwd_e_rt = FWD_NONE;
    if      (fwd_ok(e_q.raddr1, m_q.waddr, m_q.tnew)) hz.fwd_e_rt = FWD_M;
    else if (fwd_ok(e_q.raddr1, w_q.waddr, w_q.tnew)) hz.fwd_e_rt = FWD_W;

    hz.fwd_m_rt = fwd_ok(m_q.raddr1, w_q.waddr, w_q.tnew);
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count stalled cycles, wrapping naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios followed by random
// instruction streams, all checked against an instruction-level model.
module tb_hazard_ctrl;
  import cpu_hazard_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hz();
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  // ---------------- reference model ----------------
  // One record per instruction; tn is Tnew as counted at D, and the
  // remaining latency in pipe slot k (1=E, 2=M, 3=W) is max(tn - k, 0).
  typedef struct {
    logic [4:0] r0, r1, w;
    int t0, t1, tn, md;
  } ins_t;

  ins_t pipe [1:3];
  ins_t cur_d;
  ins_t nop_i;
  int   cyc = 0;
  int   md_free_at = 0;
  int   exp_cnt = 0;
  logic exp_stall;
  logic [1:0] exp_fd_rs, exp_fd_rt, exp_fe_rs, exp_fe_rt;
  logic exp_fm_rt;

  int checks = 0;
  int failures = 0;
  logic cap_stall;
  logic [1:0] cap_fd_rs, cap_fd_rt;

  function automatic ins_t mk(int r0, int r1, int t0, int t1, int w, int tn, int md);
    ins_t x;
    x.r0 = 5'(r0); x.r1 = 5'(r1); x.w = 5'(w);
    x.t0 = t0; x.t1 = t1; x.tn = tn; x.md = md;
    return x;
  endfunction

  function automatic int rem(int k);
    return (pipe[k].tn > k) ? pipe[k].tn - k : 0;
  endfunction

  // Nearest slot in [lo..3] holding a finished value of reg a; 0 if none.
  function automatic int src_of(logic [4:0] a, int lo);
    for (int k = lo; k <= 3; k++)
      if (a != 0 && a == pipe[k].w && rem(k) == 0) return k;
    return 0;
  endfunction

  task automatic model_eval();
    exp_stall = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      if (cur_d.r0 != 0 && cur_d.r0 == pipe[k].w && cur_d.t0 < rem(k)) exp_stall = 1'b1;
      if (cur_d.r1 != 0 && cur_d.r1 == pipe[k].w && cur_d.t1 < rem(k)) exp_stall = 1'b1;
    end
    if (cur_d.md != 0 && (cyc < md_free_at || pipe[1].md == 1 || pipe[1].md == 2))
      exp_stall = 1'b1;
    exp_fd_rs = 2'(src_of(cur_d.r0, 1));
    exp_fd_rt = 2'(src_of(cur_d.r1, 1));
    exp_fe_rs = 2'(src_of(pipe[1].r0, 2));
    exp_fe_rt = 2'(src_of(pipe[1].r1, 2));
    exp_fm_rt = (src_of(pipe[2].r1, 3) == 3);
  endtask

  task automatic model_advance();
    if (pipe[1].md == 1) md_free_at = cyc + 1 + MULT_N;
    else if (pipe[1].md == 2) md_free_at = cyc + 1 + DIV_N;
    pipe[3] = pipe[2];
    pipe[2] = pipe[1];
    pipe[1] = exp_stall ? nop_i : cur_d;
    if (exp_stall) exp_cnt++;
    cyc++;
  endtask

  task automatic model_clear();
    for (int k = 1; k <= 3; k++) pipe[k] = nop_i;
    md_free_at = cyc;
    exp_cnt = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(ins_t x);
    cur_d = x;
    hz.d_raddr0 = x.r0;
    hz.d_raddr1 = x.r1;
    hz.d_tuse0  = 3'(x.t0);
    hz.d_tuse1  = 3'(x.t1);
    hz.d_waddr  = x.w;
    hz.d_tnew   = 3'(x.tn);
    hz.d_md_op  = 2'(x.md);
  endtask

  task automatic eval_point();
    @(negedge clk);
    model_eval();
    chk("stall",    32'(hz.stall),    32'(exp_stall));
    chk("fwd_d_rs", 32'(hz.fwd_d_rs), 32'(exp_fd_rs));
    chk("fwd_d_rt", 32'(hz.fwd_d_rt), 32'(exp_fd_rt));
    chk("fwd_e_rs", 32'(hz.fwd_e_rs), 32'(exp_fe_rs));
    chk("fwd_e_rt", 32'(hz.fwd_e_rt), 32'(exp_fe_rt));
    chk("fwd_m_rt", 32'(hz.fwd_m_rt), 32'(exp_fm_rt));
`ifdef HAZARD_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 32'(exp_cnt));
`endif
    cap_stall = hz.stall;
    cap_fd_rs = hz.fwd_d_rs;
    cap_fd_rt = hz.fwd_d_rt;
  endtask

  task automatic advance();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  // Present x at D until it is accepted; returns the number of stall cycles.
  task automatic issue(ins_t x, output int stalls);
    logic done;
    done = 1'b0;
    stalls = 0;
    drive(x);
    for (int n = 0; n < 40 && !done; n++) begin
      eval_point();
      if (!exp_stall) done = 1'b1;
      else stalls++;
      advance();
    end
    chk("issue_accepted", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    model_clear();
    cyc++;
    #1;
    reset = 1'b0;
  endtask

  task automatic flush();
    int s;
    for (int i = 0; i < 3; i++) issue(nop_i, s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    ins_t r;
    nop_i = mk(0, 0, 7, 7, 0, 0, 0);
    drive(nop_i);
    for (int k = 1; k <= 3; k++) pipe[k] = nop_i;
    do_reset();

    // Reset state.
    eval_point();
    chk("rst_stall", 32'(hz.stall), 32'd0);
    chk("rst_fwd_d_rs", 32'(hz.fwd_d_rs), 32'(FWD_NONE));
    advance();

    // 1: lw $1 then addu $3,$1,$2 -> one stall, then E takes rs from W.
    issue(mk(2, 0, 1, 7, 1, 3, 0), s);
    issue(mk(1, 2, 1, 1, 3, 1, 0), s);
    chk("t1_stalls", s, 1);
    drive(nop_i);
    eval_point();
    chk("t1_fwd_e_rs", 32'(hz.fwd_e_rs), 32'(FWD_W));
    advance();
    flush();

    // 2: lw $1 then beq $1,$2 -> two stalls, then D takes rs from W.
    issue(mk(2, 0, 1, 7, 1, 3, 0), s);
    issue(mk(1, 2, 0, 0, 0, 0, 0), s);
    chk("t2_stalls", s, 2);
    chk("t2_fwd_d_rs", 32'(cap_fd_rs), 32'(FWD_W));
    chk("t2_stall_after", 32'(cap_stall), 32'd0);
    flush();

    // 3: ori $1 then sw $1,0($2) -> no stall, E rt from M.
    issue(mk(2, 0, 1, 7, 1, 2, 0), s);
    issue(mk(2, 1, 1, 2, 0, 0, 0), s);
    chk("t3_stalls", s, 0);
    drive(nop_i);
    eval_point();
    chk("t3_fwd_e_rt", 32'(hz.fwd_e_rt), 32'(FWD_M));
    advance();
    flush();

    // 4: mult then mflo -> six stall cycles.
    issue(mk(3, 4, 1, 1, 0, 0, 1), s);
    issue(mk(0, 0, 7, 7, 5, 1, 3), s);
    chk("t4_stalls", s, 6);
    flush();

    // 5: writes to $0 never stall or forward.
    issue(mk(0, 0, 1, 7, 0, 2, 0), s);
    issue(mk(0, 0, 1, 1, 3, 1, 0), s);
    chk("t5_stalls", s, 0);
    chk("t5_fwd_d_rs", 32'(cap_fd_rs), 32'(FWD_NONE));
    chk("t5_fwd_d_rt", 32'(cap_fd_rt), 32'(FWD_NONE));
    flush();

    // div then mfhi: full divide latency.
    issue(mk(3, 4, 1, 1, 0, 0, 2), s);
    issue(mk(0, 0, 7, 7, 6, 1, 3), s);
    chk("div_stalls", s, DIV_N + 1);
    flush();

    // 6: div, mfhi waiting, reset during busy.
    issue(mk(3, 4, 1, 1, 0, 0, 2), s);
    drive(mk(0, 0, 7, 7, 6, 1, 3));
    eval_point();
    chk("t6_stall_pre", 32'(hz.stall), 32'd1);
    advance();
    eval_point();
    advance();
    do_reset();
    eval_point();
    chk("t6_stall", 32'(hz.stall), 32'd0);
    chk("t6_fwd_e_rs", 32'(hz.fwd_e_rs), 32'(FWD_NONE));
    chk("t6_fwd_m_rt", 32'(hz.fwd_m_rt), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
    chk("t6_stall_cnt", stall_cnt, 32'd0);
`endif
    advance();
    flush();

    // Random instruction streams over a small register set.
    r = nop_i;
    for (int n = 0; n < 600; n++) begin
      int m;
      if (!exp_stall) begin
        m = int'($urandom_range(0, 11));
        r = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
               (m >= 9) ? m - 8 : 0);
      end
      drive(r);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        exp_stall = 1'b0;
      end else begin
        eval_point();
        advance();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
